// File: rtl/subtree_gather_pkg.sv
// Shared constants and helpers for the subtree gather (fan-in) block.
//   NUM_CHILD_DEF / DATA_W_DEF / CNT_W_DEF : default parameter values
//   id_w(n)                                : index width for n children, minimum 1
//   child_id_t                             : child index type at the default size
package subtree_gather_pkg;

   localparam int NUM_CHILD_DEF = 5;
   localparam int DATA_W_DEF    = 16;
   localparam int CNT_W_DEF     = 8;

   function automatic int id_w(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

   typedef logic [id_w(NUM_CHILD_DEF)-1:0] child_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : per-requester request
//   ptr     : index holding highest priority this cycle
//   gnt     : one-hot grant (zero when no request)
//   gnt_idx : index of the granted requester
//   any_gnt : at least one request present
// The priority pointer register lives in the instantiating block.
module rr_arbiter
   import subtree_gather_pkg::*;
#(
   parameter int N     = NUM_CHILD_DEF,
   parameter int IDX_W = id_w(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             any_gnt
);

   always_comb begin
      int unsigned idx;
      gnt     = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      idx     = 0;
      // Walk upward from ptr with wrap; first request found wins.
      for (int unsigned k = 0; k < unsigned'(N); k++) begin
         idx = k + 32'(ptr);
         if (idx >= unsigned'(N)) idx = idx - unsigned'(N);
         if (!any_gnt && req[idx]) begin
            any_gnt      = 1'b1;
            gnt[idx]     = 1'b1;
            gnt_idx      = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/subtree_gather_5to1.sv
// Merges result beats from NUM_CHILD child subtrees into one stream to the parent.
//   clk, rst    : clock, asynchronous active-high reset
//   child_valid : per-child beat valid
//   child_data  : child i payload at [i*DATA_W +: DATA_W]
//   child_ready : per-child accept, one-hot or zero
//   out_valid   : merged beat valid (registered)
//   out_data    : merged payload (registered)
//   out_id      : source child index of out_data
//   out_ready   : parent accept
//   beat_cnt    : saturating count of beats accepted from children
module subtree_gather_5to1
   import subtree_gather_pkg::*;
#(
   parameter int NUM_CHILD = NUM_CHILD_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CHILD-1:0]        child_valid,
   input  logic [NUM_CHILD*DATA_W-1:0] child_data,
   output logic [NUM_CHILD-1:0]        child_ready,
   output logic                        out_valid,
   output logic [DATA_W-1:0]           out_data,
   output logic [id_w(NUM_CHILD)-1:0]  out_id,
   input  logic                        out_ready,
   output logic [CNT_W-1:0]            beat_cnt
);

   localparam int ID_W = id_w(NUM_CHILD);

   logic [ID_W-1:0]      rr_ptr;
   logic [NUM_CHILD-1:0] gnt;
   logic [ID_W-1:0]      gnt_idx;
   logic                 any_gnt;
   logic                 load_en;
   logic                 transfer;
   logic [DATA_W-1:0]    sel_data;

   rr_arbiter #(
      .N     (NUM_CHILD),
      .IDX_W (ID_W)
   ) u_arb (
      .req     (child_valid),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any_gnt (any_gnt)
   );

   // Output stage can take a beat when empty or being drained this cycle.
   assign load_en  = !out_valid || out_ready;
   assign transfer = any_gnt && load_en && !rst;

   always_comb begin
      child_ready = '0;
      if (!rst && load_en) child_ready = gnt;
   end

   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < unsigned'(NUM_CHILD); i++) begin
         if (gnt[i]) sel_data = child_data[i*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= '0;
         rr_ptr    <= '0;
         beat_cnt  <= '0;
      end else if (transfer) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_id    <= gnt_idx;
         rr_ptr    <= (gnt_idx == ID_W'(NUM_CHILD-1)) ? '0 : gnt_idx + 1'b1;
         if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_subtree_gather_5to1.sv
// Self-checking bench for subtree_gather_5to1: directed scenarios plus randomized
// traffic against a behavioural model. A second instance with a 4-bit counter
// exercises counter saturation on the same stimulus.
module tb_subtree_gather_5to1;

   localparam int N  = 5;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    child_valid;
   logic [N*DW-1:0] child_data;
   logic            out_ready;

   logic [N-1:0]    child_ready_a, child_ready_b;
   logic            out_valid_a, out_valid_b;
   logic [DW-1:0]   out_data_a, out_data_b;
   logic [2:0]      out_id_a, out_id_b;
   logic [7:0]      beat_cnt_a;
   logic [3:0]      beat_cnt_b;

   subtree_gather_5to1 #(.NUM_CHILD(N), .DATA_W(DW), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .child_valid(child_valid), .child_data(child_data),
      .child_ready(child_ready_a), .out_valid(out_valid_a), .out_data(out_data_a),
      .out_id(out_id_a), .out_ready(out_ready), .beat_cnt(beat_cnt_a)
   );

   subtree_gather_5to1 #(.NUM_CHILD(N), .DATA_W(DW), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .child_valid(child_valid), .child_data(child_data),
      .child_ready(child_ready_b), .out_valid(out_valid_b), .out_data(out_data_b),
      .out_id(out_id_b), .out_ready(out_ready), .beat_cnt(beat_cnt_b)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Behavioural model state
   int          m_ptr;
   bit          m_valid;
   logic [15:0] m_data;
   int          m_id;
   int          m_cnt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v);
      for (int k = 0; k < N; k++) begin
         if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_valid = 0; m_data = '0; m_id = 0; m_cnt = 0;
   endtask

   task automatic check_outputs();
      check_eq("out_valid_a", 32'(out_valid_a), 32'(m_valid));
      check_eq("out_data_a",  32'(out_data_a),  32'(m_data));
      check_eq("out_id_a",    32'(out_id_a),    32'(m_id));
      check_eq("beat_cnt_a",  32'(beat_cnt_a),  32'((m_cnt > 255) ? 255 : m_cnt));
      check_eq("out_valid_b", 32'(out_valid_b), 32'(m_valid));
      check_eq("out_data_b",  32'(out_data_b),  32'(m_data));
      check_eq("out_id_b",    32'(out_id_b),    32'(m_id));
      check_eq("beat_cnt_b",  32'(beat_cnt_b),  32'((m_cnt > 15) ? 15 : m_cnt));
   endtask

   // Called just after a rising edge; drives inputs, checks ready mid-cycle,
   // then checks registered outputs just after the next rising edge.
   task automatic cycle(input logic [N-1:0] v, input logic ordy);
      int g;
      bit ld;
      logic [N-1:0] exp_rdy;
      child_valid = v;
      out_ready   = ordy;
      @(negedge clk);
      g  = pick(v);
      ld = !m_valid || ordy;
      exp_rdy = (g >= 0 && ld) ? N'(1 << g) : '0;
      check_eq("child_ready_a", 32'(child_ready_a), 32'(exp_rdy));
      check_eq("child_ready_b", 32'(child_ready_b), 32'(exp_rdy));
      @(posedge clk);
      #1;
      if (g >= 0 && ld) begin
         m_valid = 1;
         m_data  = child_data[g*DW +: DW];
         m_id    = g;
         m_ptr   = (g + 1) % N;
         m_cnt++;
      end else if (m_valid && ordy) begin
         m_valid = 0;
      end
      check_outputs();
   endtask

   initial begin
      rst = 1'b1;
      child_valid = '0;
      child_data  = '0;
      out_ready   = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      rst = 1'b0;

      // Round-robin order with all children valid
      for (int i = 0; i < N; i++) child_data[i*DW +: DW] = 16'(i << 4);
      for (int i = 0; i < 10; i++) begin
         cycle('1, 1'b1);
         check_eq("rr_order", 32'(out_id_a), 32'(i % N));
         check_eq("rr_data", 32'(out_data_a), 32'((i % N) << 4));
      end
      check_eq("cnt_after_10", 32'(beat_cnt_a), 32'd10);

      // Reset mid-run with a beat pending
      check_eq("pending_before_rst", 32'(out_valid_a), 32'd1);
      rst = 1'b1;
      #1;
      check_eq("rst_out_valid", 32'(out_valid_a), 32'd0);
      check_eq("rst_beat_cnt", 32'(beat_cnt_a), 32'd0);
      check_eq("rst_child_ready", 32'(child_ready_a), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      child_data[3*DW +: DW] = 16'h0033;
      cycle(5'b01000, 1'b1);
      check_eq("post_rst_id", 32'(out_id_a), 32'd3);
      check_eq("post_rst_data", 32'(out_data_a), 32'h0033);

      // Backpressure
      cycle('0, 1'b1);
      child_data[2*DW +: DW] = 16'hBEEF;
      child_data[4*DW +: DW] = 16'h4444;
      cycle(5'b00100, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cycle(5'b10000, 1'b0);
         check_eq("bp_hold", 32'(out_data_a), 32'hBEEF);
         check_eq("bp_ready", 32'(child_ready_a), 32'd0);
      end
      cycle(5'b10000, 1'b1);
      check_eq("bp_release_id", 32'(out_id_a), 32'd4);
      check_eq("bp_release_data", 32'(out_data_a), 32'h4444);

      // Wrap after grant 4
      cycle(5'b10001, 1'b1);
      check_eq("wrap_first", 32'(out_id_a), 32'd0);
      cycle(5'b10001, 1'b1);
      check_eq("wrap_second", 32'(out_id_a), 32'd4);

      // Idle cycles must not rotate priority
      cycle(5'b00010, 1'b1);
      check_eq("idle_grant1", 32'(out_id_a), 32'd1);
      repeat (3) cycle('0, 1'b1);
      cycle(5'b00110, 1'b1);
      check_eq("idle_next", 32'(out_id_a), 32'd2);

      // Randomized traffic; long enough to saturate both counters
      for (int i = 0; i < 700; i++) begin
         child_data = {$urandom, $urandom, $urandom};
         cycle(N'($urandom), ($urandom_range(0, 3) != 0));
      end
      check_eq("sat_cnt_b", 32'(beat_cnt_b), 32'd15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
